// File: rtl/id_control_decode_if.sv
// ID-stage control bus: instruction/NOP-select in, registered EX control bundle out,
// plus the IF-stage next-fetch address selector signals.
interface id_control_decode_if;
   logic [31:0] instruction;
   logic        controlMux;
   logic [8:0]  nPC;
   logic [31:0] TA;
   logic        S;
   logic [31:0] Address;
   logic [3:0]  EX_ALU_OP;
   logic        EX_LOAD_INSTR;
   logic        EX_RF_ENABLE;
   logic        EX_HI_ENABLE;
   logic        EX_LO_ENABLE;
   logic        EX_PC_PLUS8_INSTR;
   logic        EX_UB_INSTR;
   logic        EX_JALR_JR_INSTR;
   logic [1:0]  EX_DESTINATION_REGISTER;
   logic [2:0]  EX_OP_H_S;
   logic        EX_MEM_ENABLE;
   logic        EX_MEM_READWRITE;
   logic [1:0]  EX_MEM_SIZE;
   logic        EX_MEM_SIGNE;

   modport master (
      output instruction, controlMux, nPC, TA, S,
      input  Address, EX_ALU_OP, EX_LOAD_INSTR, EX_RF_ENABLE, EX_HI_ENABLE, EX_LO_ENABLE,
             EX_PC_PLUS8_INSTR, EX_UB_INSTR, EX_JALR_JR_INSTR, EX_DESTINATION_REGISTER,
             EX_OP_H_S, EX_MEM_ENABLE, EX_MEM_READWRITE, EX_MEM_SIZE, EX_MEM_SIGNE
   );

   modport slave (
      input  instruction, controlMux, nPC, TA, S,
      output Address, EX_ALU_OP, EX_LOAD_INSTR, EX_RF_ENABLE, EX_HI_ENABLE, EX_LO_ENABLE,
             EX_PC_PLUS8_INSTR, EX_UB_INSTR, EX_JALR_JR_INSTR, EX_DESTINATION_REGISTER,
             EX_OP_H_S, EX_MEM_ENABLE, EX_MEM_READWRITE, EX_MEM_SIZE, EX_MEM_SIGNE
   );
endinterface

// File: rtl/id_control_decode.sv
// MIPS ID-stage control decode: instruction -> control bundle, optional NOP
// substitution, registered toward EX; also the IF next-fetch address mux.
module id_control_decode (
   input logic                 Clk,
   input logic                 Reset,
   id_control_decode_if.slave  bus
);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned NPC_W  = 9;

   localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR   = 4'h3,
                          ALU_XOR = 4'h4, ALU_NOR = 4'h5, ALU_SLL = 4'h6, ALU_SRL  = 4'h7,
                          ALU_SRA = 4'h8, ALU_SLT = 4'h9, ALU_SLTU = 4'hA,
                          ALU_PASS_A = 4'hB, ALU_PASS_B = 4'hC;

   localparam logic [2:0] OPH_RT = 3'd0, OPH_SIMM = 3'd1, OPH_ZIMM = 3'd2,
                          OPH_LUI = 3'd3, OPH_SHAMT = 3'd4;

   localparam logic [1:0] DEST_RD = 2'b00, DEST_RT = 2'b01, DEST_R31 = 2'b10;
   localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       load;
      logic       rf_en;
      logic       hi_en;
      logic       lo_en;
      logic       pc_plus8;
      logic       ub;
      logic       jalr_jr;
      logic [1:0] dest;
      logic [2:0] op_h_s;
      logic       mem_en;
      logic       mem_rw;
      logic [1:0] mem_size;
      logic       mem_signe;
   } ctrl_t;

   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rt;
   ctrl_t      dec;
   ctrl_t      muxed;
   ctrl_t      ex_q;

   assign op    = bus.instruction[31:26];
   assign funct = bus.instruction[5:0];
   assign rt    = bus.instruction[20:16];

   assign bus.Address = bus.S ? bus.TA : {(ADDR_W - NPC_W)'(0), bus.nPC};

   // Opcode/funct decode; anything not recognised yields the all-zero bundle.
   always_comb begin
      dec = '0;
      case (op)
         6'h00: begin
            dec.rf_en = 1'b1;
            dec.dest  = DEST_RD;
            case (funct)
               6'h20, 6'h21: dec.alu_op = ALU_ADD;
               6'h22, 6'h23: dec.alu_op = ALU_SUB;
               6'h24: dec.alu_op = ALU_AND;
               6'h25: dec.alu_op = ALU_OR;
               6'h26: dec.alu_op = ALU_XOR;
               6'h27: dec.alu_op = ALU_NOR;
               6'h2A: dec.alu_op = ALU_SLT;
               6'h2B: dec.alu_op = ALU_SLTU;
               6'h00: begin dec.alu_op = ALU_SLL; dec.op_h_s = OPH_SHAMT; end
               6'h02: begin dec.alu_op = ALU_SRL; dec.op_h_s = OPH_SHAMT; end
               6'h03: begin dec.alu_op = ALU_SRA; dec.op_h_s = OPH_SHAMT; end
               6'h04: dec.alu_op = ALU_SLL;
               6'h06: dec.alu_op = ALU_SRL;
               6'h07: dec.alu_op = ALU_SRA;
               6'h08: begin dec.jalr_jr = 1'b1; dec.rf_en = 1'b0; end
               6'h09: begin dec.jalr_jr = 1'b1; dec.pc_plus8 = 1'b1; end
               6'h10, 6'h12: dec.alu_op = ALU_ADD;
               6'h11: begin dec.rf_en = 1'b0; dec.hi_en = 1'b1; dec.alu_op = ALU_PASS_A; end
               6'h13: begin dec.rf_en = 1'b0; dec.lo_en = 1'b1; dec.alu_op = ALU_PASS_A; end
               default: dec = '0;
            endcase
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            dec.rf_en = 1'b1;
            dec.dest  = DEST_RT;
            case (op)
               6'h0A:   begin dec.alu_op = ALU_SLT;    dec.op_h_s = OPH_SIMM; end
               6'h0B:   begin dec.alu_op = ALU_SLTU;   dec.op_h_s = OPH_SIMM; end
               6'h0C:   begin dec.alu_op = ALU_AND;    dec.op_h_s = OPH_ZIMM; end
               6'h0D:   begin dec.alu_op = ALU_OR;     dec.op_h_s = OPH_ZIMM; end
               6'h0E:   begin dec.alu_op = ALU_XOR;    dec.op_h_s = OPH_ZIMM; end
               6'h0F:   begin dec.alu_op = ALU_PASS_B; dec.op_h_s = OPH_LUI;  end
               default: begin dec.alu_op = ALU_ADD;    dec.op_h_s = OPH_SIMM; end
            endcase
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            dec.alu_op    = ALU_ADD;
            dec.op_h_s    = OPH_SIMM;
            dec.load      = 1'b1;
            dec.rf_en     = 1'b1;
            dec.dest      = DEST_RT;
            dec.mem_en    = 1'b1;
            dec.mem_size  = (op == 6'h23) ? SZ_WORD :
                            (op == 6'h21 || op == 6'h25) ? SZ_HALF : SZ_BYTE;
            dec.mem_signe = (op == 6'h20 || op == 6'h21);
         end
         6'h28, 6'h29, 6'h2B: begin
            dec.alu_op   = ALU_ADD;
            dec.op_h_s   = OPH_SIMM;
            dec.mem_en   = 1'b1;
            dec.mem_rw   = 1'b1;
            dec.mem_size = (op == 6'h2B) ? SZ_WORD : (op == 6'h29) ? SZ_HALF : SZ_BYTE;
         end
         6'h04, 6'h05, 6'h06, 6'h07: dec.alu_op = ALU_SUB;
         6'h01: begin
            // REGIMM: rt selects the branch flavour; bit 4 marks the linking forms
            if (rt == 5'b00000 || rt == 5'b00001) begin
               dec.alu_op = ALU_SUB;
            end else if (rt == 5'b10000 || rt == 5'b10001) begin
               dec.alu_op   = ALU_SUB;
               dec.rf_en    = 1'b1;
               dec.dest     = DEST_R31;
               dec.pc_plus8 = 1'b1;
            end
         end
         6'h02: dec.ub = 1'b1;
         6'h03: begin
            dec.ub       = 1'b1;
            dec.pc_plus8 = 1'b1;
            dec.rf_en    = 1'b1;
            dec.dest     = DEST_R31;
         end
         default: dec = '0;
      endcase
      // All-zero word is the canonical NOP, not an SLL
      if (bus.instruction == 32'h0) dec = '0;
   end

   assign muxed = bus.controlMux ? ctrl_t'(0) : dec;

   always_ff @(posedge Clk) begin
      if (Reset) ex_q <= '0;
      else       ex_q <= muxed;
   end

   assign bus.EX_ALU_OP               = ex_q.alu_op;
   assign bus.EX_LOAD_INSTR           = ex_q.load;
   assign bus.EX_RF_ENABLE            = ex_q.rf_en;
   assign bus.EX_HI_ENABLE            = ex_q.hi_en;
   assign bus.EX_LO_ENABLE            = ex_q.lo_en;
   assign bus.EX_PC_PLUS8_INSTR       = ex_q.pc_plus8;
   assign bus.EX_UB_INSTR             = ex_q.ub;
   assign bus.EX_JALR_JR_INSTR        = ex_q.jalr_jr;
   assign bus.EX_DESTINATION_REGISTER = ex_q.dest;
   assign bus.EX_OP_H_S               = ex_q.op_h_s;
   assign bus.EX_MEM_ENABLE           = ex_q.mem_en;
   assign bus.EX_MEM_READWRITE        = ex_q.mem_rw;
   assign bus.EX_MEM_SIZE             = ex_q.mem_size;
   assign bus.EX_MEM_SIGNE            = ex_q.mem_signe;
endmodule

// File: tb/tb_id_control_decode.sv
// Directed bench for id_control_decode: expected EX bundles are queued when an
// instruction is driven and checked one edge later; Address mux checked directly.
module tb_id_control_decode;
   typedef struct packed {
      logic [3:0] alu;
      logic       load;
      logic       rf;
      logic       hi;
      logic       lo;
      logic       pc8;
      logic       ub;
      logic       jr;
      logic [1:0] dest;
      logic [2:0] ophs;
      logic       men;
      logic       mrw;
      logic [1:0] size;
      logic       signe;
   } bundle_t;

   typedef struct {
      string   tag;
      bundle_t exp;
   } sb_entry_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   sb_entry_t sb_q[$];

   id_control_decode_if bus_i ();

   id_control_decode dut (
      .Clk   (clk),
      .Reset (reset),
      .bus   (bus_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bundle_t mk(input logic [3:0] alu, input logic [2:0] ophs,
                                  input logic [1:0] dest, input logic rf, input logic load,
                                  input logic men, input logic mrw, input logic [1:0] size,
                                  input logic signe, input logic pc8, input logic ub,
                                  input logic jr, input logic hi, input logic lo);
      bundle_t b;
      b.alu = alu;   b.ophs = ophs; b.dest = dest; b.rf = rf;       b.load = load;
      b.men = men;   b.mrw = mrw;   b.size = size; b.signe = signe; b.pc8 = pc8;
      b.ub = ub;     b.jr = jr;     b.hi = hi;     b.lo = lo;
      return b;
   endfunction

   function automatic bundle_t observed();
      bundle_t b;
      b.alu  = bus_i.EX_ALU_OP;          b.load  = bus_i.EX_LOAD_INSTR;
      b.rf   = bus_i.EX_RF_ENABLE;       b.hi    = bus_i.EX_HI_ENABLE;
      b.lo   = bus_i.EX_LO_ENABLE;       b.pc8   = bus_i.EX_PC_PLUS8_INSTR;
      b.ub   = bus_i.EX_UB_INSTR;        b.jr    = bus_i.EX_JALR_JR_INSTR;
      b.dest = bus_i.EX_DESTINATION_REGISTER;
      b.ophs = bus_i.EX_OP_H_S;          b.men   = bus_i.EX_MEM_ENABLE;
      b.mrw  = bus_i.EX_MEM_READWRITE;   b.size  = bus_i.EX_MEM_SIZE;
      b.signe = bus_i.EX_MEM_SIGNE;
      return b;
   endfunction

   // Drive one instruction, queue its expected bundle, check it after the edge.
   task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                       input logic cm, input bundle_t exp);
      sb_entry_t e;
      bundle_t   obs;
      reset             = rst;
      bus_i.instruction = ins;
      bus_i.controlMux  = cm;
      sb_q.push_back('{tag: tag, exp: exp});
      @(posedge clk);
      #1;
      e   = sb_q.pop_front();
      obs = observed();
      checks++;
      assert (obs === e.exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
   endtask

   task automatic chk_addr(input string tag, input logic s, input logic [8:0] npc,
                           input logic [31:0] ta, input logic [31:0] exp);
      bus_i.S   = s;
      bus_i.nPC = npc;
      bus_i.TA  = ta;
      #1;
      checks++;
      assert (bus_i.Address === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, bus_i.Address, exp);
      end
   endtask

   bundle_t z, b_add, b_lw, b_sb, b_jal, b_jr;

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      bus_i.instruction = 32'h0;
      bus_i.controlMux  = 1'b0;
      bus_i.S   = 1'b0;
      bus_i.nPC = 9'h0;
      bus_i.TA  = 32'h0;

      z     = '0;
      b_add = mk(4'h0, 3'd0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      b_lw  = mk(4'h0, 3'd1, 2'b01, 1, 1, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0);
      b_sb  = mk(4'h0, 3'd1, 2'b00, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
      b_jal = mk(4'h0, 3'd0, 2'b10, 1, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0);
      b_jr  = mk(4'h0, 3'd0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);

      @(posedge clk);
      #1;
      step("reset_with_add", 1'b1, 32'h01095020, 1'b0, z);

      chk_addr("addr_npc",     1'b0, 9'h00C, 32'h00000040, 32'h0000000C);
      chk_addr("addr_ta",      1'b1, 9'h00C, 32'h00000040, 32'h00000040);
      chk_addr("addr_npc_max", 1'b0, 9'h1FF, 32'hFFFFFFFF, 32'h000001FF);
      chk_addr("addr_ta_ones", 1'b1, 9'h1FF, 32'hFFFFFFFF, 32'hFFFFFFFF);

      step("add",  1'b0, 32'h01095020, 1'b0, b_add);
      step("lw",   1'b0, 32'h8D090004, 1'b0, b_lw);
      step("sb",   1'b0, 32'hA1090004, 1'b0, b_sb);
      step("jal",  1'b0, 32'h0C000010, 1'b0, b_jal);
      step("jr",   1'b0, 32'h01000008, 1'b0, b_jr);
      step("lw_nop",  1'b0, 32'h8D090004, 1'b1, z);
      step("lw_back", 1'b0, 32'h8D090004, 1'b0, b_lw);
      step("zero_word", 1'b0, 32'h00000000, 1'b0, z);
      step("undef_op",  1'b0, 32'hFC000000, 1'b0, z);
      step("undef_funct",  1'b0, 32'h00000001, 1'b0, z);
      step("undef_regimm", 1'b0, 32'h04020004, 1'b0, z);

      step("sub",   1'b0, 32'h01095022, 1'b0, mk(4'h1, 3'd0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("nor",   1'b0, 32'h01095027, 1'b0, mk(4'h5, 3'd0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("sll",   1'b0, 32'h00095100, 1'b0, mk(4'h6, 3'd4, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("srav",  1'b0, 32'h01095007, 1'b0, mk(4'h8, 3'd0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("jalr",  1'b0, 32'h0100F809, 1'b0, mk(4'h0, 3'd0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0));
      step("mthi",  1'b0, 32'h01000011, 1'b0, mk(4'hB, 3'd0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0));
      step("mtlo",  1'b0, 32'h01000013, 1'b0, mk(4'hB, 3'd0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1));
      step("mflo",  1'b0, 32'h00005012, 1'b0, b_add);
      step("sltiu", 1'b0, 32'h2D09000F, 1'b0, mk(4'hA, 3'd1, 2'b01, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("ori",   1'b0, 32'h3509000F, 1'b0, mk(4'h3, 3'd2, 2'b01, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("lui",   1'b0, 32'h3C091234, 1'b0, mk(4'hC, 3'd3, 2'b01, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("lb",    1'b0, 32'h81090000, 1'b0, mk(4'h0, 3'd1, 2'b01, 1, 1, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0));
      step("lh",    1'b0, 32'h85090000, 1'b0, mk(4'h0, 3'd1, 2'b01, 1, 1, 1, 0, 2'b01, 1, 0, 0, 0, 0, 0));
      step("lhu",   1'b0, 32'h95090000, 1'b0, mk(4'h0, 3'd1, 2'b01, 1, 1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0));
      step("sh",    1'b0, 32'hA5090000, 1'b0, mk(4'h0, 3'd1, 2'b00, 0, 0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 0));
      step("sw",    1'b0, 32'hAD090000, 1'b0, mk(4'h0, 3'd1, 2'b00, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0, 0, 0));
      step("beq",   1'b0, 32'h11090004, 1'b0, mk(4'h1, 3'd0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("bgez",  1'b0, 32'h04010004, 1'b0, mk(4'h1, 3'd0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
      step("bltzal",1'b0, 32'h04100004, 1'b0, mk(4'h1, 3'd0, 2'b10, 1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0));
      step("j",     1'b0, 32'h08000010, 1'b0, mk(4'h0, 3'd0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0));

      step("jal_pre_reset",  1'b0, 32'h0C000010, 1'b0, b_jal);
      step("reset_mid",      1'b1, 32'h8D090004, 1'b0, z);
      step("reset_over_nop", 1'b1, 32'h8D090004, 1'b1, z);
      step("post_reset_lw",  1'b0, 32'h8D090004, 1'b0, b_lw);

      checks++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed=%0d expected=0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/id_control_decode.md
Name: id_control_decode

Overview:
- Instruction-decode control block for the 5-stage MIPS pipeline.
- Decodes the 32-bit instruction word into pipeline control signals.
- Optionally replaces them with an all-zero NOP bundle (hazard-unit request) and registers the result toward the EX stage.
- Also provides the IF-stage next-fetch address selector, choosing between the sequential nPC and a jump/branch target address.

Parameters:
- none.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- instruction  input  32  instruction word in ID
- controlMux  input  1  1 = force NOP bundle (all zero), 0 = pass decoded bundle
- nPC  input  9  sequential next PC
- TA  input  32  target address
- S  input  1  1 = select TA, 0 = select nPC
- Address  output  32  next-fetch address; combinational
- EX_ALU_OP  output  4  ALU operation
- EX_LOAD_INSTR  output  1  instruction is a load
- EX_RF_ENABLE  output  1  register-file write enable
- EX_HI_ENABLE  output  1  HI write enable
- EX_LO_ENABLE  output  1  LO write enable
- EX_PC_PLUS8_INSTR  output  1  write-back value is PC+8 (link)
- EX_UB_INSTR  output  1  unconditional jump (J/JAL)
- EX_JALR_JR_INSTR  output  1  register jump (JR/JALR)
- EX_DESTINATION_REGISTER  output  2  00 = rd, 01 = rt, 10 = r31
- EX_OP_H_S  output  3  operand-2 handler select
- EX_MEM_ENABLE  output  1  data-memory access
- EX_MEM_READWRITE  output  1  1 = write (store), 0 = read
- EX_MEM_SIZE  output  2  00 = byte, 01 = half, 10 = word
- EX_MEM_SIGNE  output  1  sign-extend load data

Behaviour:

Address mux:
- Address = S ? TA : {23'b0, nPC}. Purely combinational, independent of Clk and Reset.

Decode (combinational, on instruction[31:26] = op, [5:0] = funct):
- Every signal not listed for an instruction is 0.
- ALU_OP encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOR, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLT, 1010 SLTU, 1011 PASS_A, 1100 PASS_B.
- OP_H_S encoding: 000 rt, 001 simm16, 010 zimm16, 011 imm16<<16, 100 shamt.

R-type (op = 000000):
- Common: RF_ENABLE = 1, dest = 00.
- Arithmetic/logic:
  - ADD/ADDU (20/21) → ADD.
  - SUB/SUBU (22/23) → SUB.
  - AND/OR/XOR/NOR (24–27) → respective op.
  - SLT (2A) → SLT; SLTU (2B) → SLTU.
- Shifts:
  - SLL/SRL/SRA (00/02/03) → shift op, OP_H_S = 100.
  - SLLV/SRLV/SRAV (04/06/07) → shift op, OP_H_S = 000.
- Jumps:
  - JR (08): JALR_JR = 1, RF_ENABLE = 0.
  - JALR (09): JALR_JR = 1, PC_PLUS8 = 1.
- HI/LO:
  - MFHI/MFLO (10/12): RF_ENABLE = 1, ALU_OP = 0000.
  - MTHI/MTLO (11/13): RF_ENABLE = 0, HI_ENABLE or LO_ENABLE = 1, ALU_OP = PASS_A.

Immediate ALU:
- Common: RF_ENABLE = 1, dest = 01.
- ADDI/ADDIU (08/09): ADD, OP_H_S = 001.
- SLTI (0A): SLT, 001. SLTIU (0B): SLTU, 001.
- ANDI/ORI/XORI (0C/0D/0E): respective op, 010.
- LUI (0F): PASS_B, 011.

Loads (LB 20, LH 21, LW 23, LBU 24, LHU 25):
- ALU ADD, OP_H_S = 001, LOAD = 1, RF_ENABLE = 1, dest = 01, MEM_ENABLE = 1, READWRITE = 0.
- Size per mnemonic; SIGNE = 1 for LB/LH only.

Stores (SB 28, SH 29, SW 2B):
- ALU ADD, OP_H_S = 001, MEM_ENABLE = 1, READWRITE = 1, size per mnemonic, RF_ENABLE = 0.

Branches:
- BEQ/BNE/BLEZ/BGTZ (04–07) and REGIMM (01) BLTZ/BGEZ: ALU SUB, no write.
- BLTZAL/BGEZAL (REGIMM rt = 10000/10001): additionally RF_ENABLE = 1, dest = 10, PC_PLUS8 = 1.

Jumps:
- J (02): UB = 1.
- JAL (03): UB = 1, PC_PLUS8 = 1, RF_ENABLE = 1, dest = 10.

Special cases:
- instruction == 32'h0 (canonical NOP) and any undefined opcode/funct → entire bundle 0.

NOP mux:
- Bundle = controlMux ? all-zero : decoded bundle.

Register stage:
- On rising Clk: Reset = 1 → all EX_* outputs 0; else EX_* ← muxed bundle.
- Latency: 1 cycle from instruction/controlMux to EX_*.
- Reset has priority over controlMux and instruction.

Test Plan:
- Reset = 1 one edge with instruction = ADD → all EX_* = 0. Then S = 0, nPC = 9'h00C → Address = 32'h0000000C; S = 1, TA = 32'h00000040 → Address = 32'h40.
- instruction = 32'h01095020 (add $10,$8,$9), controlMux = 0 → after one edge: ALU_OP = 0000, RF_ENABLE = 1, DEST = 00, OP_H_S = 000, all memory bits 0.
- instruction = 32'h8D090004 (lw) → LOAD = 1, MEM_ENABLE = 1, READWRITE = 0, SIZE = 10, SIGNE = 0, DEST = 01, OP_H_S = 001. Then 32'hA1090004 (sb) → READWRITE = 1, SIZE = 00, RF_ENABLE = 0.
- instruction = 32'h0C000010 (jal) → UB = 1, PC_PLUS8 = 1, DEST = 10, RF_ENABLE = 1. Then 32'h01000008 (jr) → JALR_JR = 1, RF_ENABLE = 0.
- Same lw with controlMux = 1 → next edge all EX_* = 0; controlMux back to 0 → lw bundle reappears one edge later.
- instruction = 32'h00000000 and 32'hFC000000 (undefined) → all EX_* = 0; Reset asserted mid-stream with a valid instruction → zeros on that same edge.
